instr_sequencer: RTL and testbench

Top-level instruction sequencer for the microcontroller control path. It fetches each 16-bit instruction over the shared bus through the MAR/MDR and memory handshake (MFC), latches it into the instruction register, and decodes the opcode. It then dispatches a one-cycle start pulse to the owning execution FSM (memory, move or ALU) and holds the bus grant until that unit pulses done. Illegal opcodes, halts and, optionally, stalled handshakes are trapped into terminal states.

---
 rtl/seq_pkg.sv | 53 +++++
 rtl/seq_watchdog.sv | 33 +++
 rtl/instr_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - OP_*        : opcode constants (ir[15:12])
//   - UNIT_*      : execution-unit indices, matching unit_start/unit_done bits
//   - GRANT_*     : bus_grant encodings
//   - FAULT_*     : fault_code values
package seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_ADDR,
    FETCH_MEM,
    FETCH_MDR,
    LOAD_IR,
    DECODE,
    DISPATCH,
    WAIT_DONE,
    HALT,
    FAULT
  } seq_state_t;

  localparam logic [3:0] OP_MOVE0     = 4'h0;
  localparam logic [3:0] OP_MOVE1     = 4'h1;
  localparam logic [3:0] OP_LOAD      = 4'h2;
  localparam logic [3:0] OP_STORE     = 4'h3;
  localparam logic [3:0] OP_ALU_FIRST = 4'h4;
  localparam logic [3:0] OP_ALU_LAST  = 4'hB;
  localparam logic [3:0] OP_HALT      = 4'hF;

  localparam logic [1:0] UNIT_MEM  = 2'd0;
  localparam logic [1:0] UNIT_MOVE = 2'd1;
  localparam logic [1:0] UNIT_ALU  = 2'd2;

  localparam logic [1:0] GRANT_SEQ  = 2'b00;
  localparam logic [1:0] GRANT_MEM  = 2'b01;
  localparam logic [1:0] GRANT_MOVE = 2'b10;
  localparam logic [1:0] GRANT_ALU  = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_MFC_TO  = 2'b10;
  localparam logic [1:0] FAULT_DONE_TO = 2'b11;

  // Maps a unit index to the bus owner code it is granted.
  function automatic logic [1:0] grant_of(input logic [1:0] unit);
    case (unit)
      UNIT_MEM:  return GRANT_MEM;
      UNIT_MOVE: return GRANT_MOVE;
      default:   return GRANT_ALU;
    endcase
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: clearable wait-cycle counter for the sequencer's handshake
// states. Only instantiated when SEQ_WATCHDOG_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   waiting         high while the sequencer sits in a wait state
//   expired         high during the TIMEOUT_CYCLES-th consecutive wait cycle
module seq_watchdog #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic expired
);

  logic [7:0] count;

  // Any non-wait cycle clears the count, so each wait state entry starts
  // from zero. The count saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (!waiting) begin
      count <= 8'd0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of wait cycles already completed.
  assign expired = waiting && (count == (TIMEOUT_CYCLES - 8'd1));

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 16-bit instructions over the shared bus, decodes
// the opcode and dispatches a start pulse to the memory, move or ALU FSM,
// holding the bus grant until that unit reports done.
// Optional feature macro: SEQ_WATCHDOG_EN (bounded MFC/done waits).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   run              allow a new fetch
//   MFC              memory function complete
//   bus_in[15:0]     shared bus (MDR contents while mdrOut=1)
//   unit_done[2:0]   done pulses: [0] memory, [1] move, [2] ALU
//   ir[15:0]         instruction register
//   unit_start[2:0]  one-hot start pulse
//   bus_grant[1:0]   bus owner: 00 seq, 01 mem, 10 move, 11 ALU
//   pcOut..pcInc     fetch-phase datapath controls
//   halted, fault    terminal-state flags
//   fault_code[1:0]  01 illegal, 10 MFC timeout, 11 done timeout
module instr_sequencer
  import seq_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        MFC,
  input  logic [15:0] bus_in,
  input  logic [2:0]  unit_done,
  output logic [15:0] ir,
  output logic [2:0]  unit_start,
  output logic [1:0]  bus_grant,
  output logic        pcOut,
  output logic        marIn,
  output logic        memEN,
  output logic        RW,
  output logic        mdrReadEN,
  output logic        mdrOut,
  output logic        irIn,
  output logic        pcInc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code
);

  seq_state_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] fcode_q, fcode_d;
  logic       sel_done;
  logic       wd_expired;

`ifdef SEQ_WATCHDOG_EN
  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .waiting((state_q == FETCH_MEM) || (state_q == WAIT_DONE)),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= UNIT_MEM;
      fcode_q <= FAULT_NONE;
      ir      <= 16'h0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fcode_q <= fcode_d;
      if (state_q == LOAD_IR) begin
        ir <= bus_in;
      end
    end
  end

  // Only the selected unit's done bit matters; the others are ignored.
  always_comb begin
    case (sel_q)
      UNIT_MEM:  sel_done = unit_done[0];
      UNIT_MOVE: sel_done = unit_done[1];
      default:   sel_done = unit_done[2];
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    fcode_d = fcode_q;
    case (state_q)
      IDLE:       if (run) state_d = FETCH_ADDR;
      FETCH_ADDR: state_d = FETCH_MEM;
      // The handshake is checked before the timeout so a coincident MFC wins.
      FETCH_MEM: begin
        if (MFC) begin
          state_d = FETCH_MDR;
        end else if (wd_expired) begin
          state_d = FAULT;
          fcode_d = FAULT_MFC_TO;
        end
      end
      FETCH_MDR:  state_d = LOAD_IR;
      LOAD_IR:    state_d = DECODE;
      DECODE: begin
        case (ir[15:12])
          OP_MOVE0, OP_MOVE1: begin
            sel_d   = UNIT_MOVE;
            state_d = DISPATCH;
          end
          OP_LOAD, OP_STORE: begin
            sel_d   = UNIT_MEM;
            state_d = DISPATCH;
          end
          OP_HALT: state_d = HALT;
          default: begin
            if ((ir[15:12] >= OP_ALU_FIRST) && (ir[15:12] <= OP_ALU_LAST)) begin
              sel_d   = UNIT_ALU;
              state_d = DISPATCH;
            end else begin
              state_d = FAULT;
              fcode_d = FAULT_ILLEGAL;
            end
          end
        endcase
      end
      DISPATCH:   state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (sel_done) begin
          state_d = run ? FETCH_ADDR : IDLE;
        end else if (wd_expired) begin
          state_d = FAULT;
          fcode_d = FAULT_DONE_TO;
        end
      end
      HALT:       state_d = HALT;
      FAULT:      state_d = FAULT;
      default:    state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only, so MFC and unit_done
  // never reach an output combinationally.
  always_comb begin
    pcOut      = 1'b0;
    marIn      = 1'b0;
    memEN      = 1'b0;
    RW         = 1'b0;
    mdrReadEN  = 1'b0;
    mdrOut     = 1'b0;
    irIn       = 1'b0;
    pcInc      = 1'b0;
    unit_start = 3'b000;
    bus_grant  = GRANT_SEQ;
    halted     = 1'b0;
    fault      = 1'b0;
    fault_code = fcode_q;
    case (state_q)
      FETCH_ADDR: begin
        pcOut = 1'b1;
        marIn = 1'b1;
      end
      FETCH_MEM: begin
        memEN = 1'b1;
        RW    = 1'b1;
      end
      FETCH_MDR: begin
        memEN     = 1'b1;
        RW        = 1'b1;
        mdrReadEN = 1'b1;
      end
      LOAD_IR: begin
        mdrOut = 1'b1;
        irIn   = 1'b1;
        pcInc  = 1'b1;
      end
      DISPATCH: begin
        unit_start = 3'b001 << sel_q;
        bus_grant  = grant_of(sel_q);
      end
      WAIT_DONE:  bus_grant = grant_of(sel_q);
      HALT:       halted = 1'b1;
      FAULT:      fault = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: self-checking bench for instr_sequencer. A transaction-
// level model derives the owning unit from the opcode ranges and the expected
// fetch control timeline from the MFC delay; randomized instructions and
// handshake delays are checked against it.
// Build with SEQ_WATCHDOG_EN defined to exercise the timeout faults.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        MFC;
  logic [15:0] bus_in;
  logic [2:0]  unit_done;
  logic [15:0] ir;
  logic [2:0]  unit_start;
  logic [1:0]  bus_grant;
  logic        pcOut, marIn, memEN, RW, mdrReadEN, mdrOut, irIn, pcInc;
  logic        halted, fault;
  logic [1:0]  fault_code;
  logic [7:0]  ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  assign ctrl = {pcOut, marIn, memEN, RW, mdrReadEN, mdrOut, irIn, pcInc};

  instr_sequencer #(
    .TIMEOUT_CYCLES(8'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .MFC       (MFC),
    .bus_in    (bus_in),
    .unit_done (unit_done),
    .ir        (ir),
    .unit_start(unit_start),
    .bus_grant (bus_grant),
    .pcOut     (pcOut),
    .marIn     (marIn),
    .memEN     (memEN),
    .RW        (RW),
    .mdrReadEN (mdrReadEN),
    .mdrOut    (mdrOut),
    .irIn      (irIn),
    .pcInc     (pcInc),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Owning unit from the opcode: 0 memory, 1 move, 2 ALU, 3 halt, 4 illegal.
  function automatic int model_unit(input logic [15:0] instr);
    int op;
    op = int'(instr[15:12]);
    if (op == 2 || op == 3) return 0;
    if (op <= 1) return 1;
    if (op >= 4 && op <= 11) return 2;
    if (op == 15) return 3;
    return 4;
  endfunction

  // Expected {pcOut,marIn,memEN,RW,mdrReadEN,mdrOut,irIn,pcInc} at cycle
  // rel after FETCH_ADDR entry, when MFC is withheld for 'low' cycles.
  function automatic logic [7:0] model_fetch_ctrl(input int rel, input int low);
    if (rel == 0) return 8'b1100_0000;
    if (rel >= 1 && rel <= low + 1) return 8'b0011_0000;
    if (rel == low + 2) return 8'b0011_1000;
    if (rel == low + 3) return 8'b0000_0111;
    return 8'b0000_0000;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    run       = 1'b0;
    MFC       = 1'b0;
    unit_done = 3'b000;
    bus_in    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one fetch; returns at the negedge of the start-pulse cycle
  // (or the HALT/FAULT cycle that replaces it).
  task automatic fetch_one(input logic [15:0] instr, input int low,
                           output int ctrl_err, output logic found);
    int rel;
    rel      = -1;
    ctrl_err = 0;
    found    = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (rel < 0 && pcOut) rel = 0;
      if (rel >= 0) begin
        if (ctrl !== model_fetch_ctrl(rel, low)) ctrl_err++;
        if (rel == low + 5) begin
          found = 1'b1;
          break;
        end
        if (unit_start !== 3'b000 || bus_grant !== 2'b00) ctrl_err++;
      end
      MFC    = (rel >= 1) && (rel == low + 1);
      bus_in = mdrOut ? instr : 16'($urandom);
      @(negedge clk);
      if (rel >= 0) rel++;
    end
    MFC = 1'b0;
  endtask

  // Starts at the DISPATCH negedge; pulses the unit's done after 'gap' idle
  // wait cycles (other done bits toggle randomly); returns one cycle later.
  task automatic wait_done(input int unit, input int gap, input logic run_next,
                           output int err);
    err = 0;
    for (int g = 0; g <= gap; g++) begin
      @(negedge clk);
      if (bus_grant !== 2'(unit + 1) || unit_start !== 3'b000 || ctrl !== 8'h00) err++;
      unit_done = 3'($urandom) & ~(3'(1 << unit));
      if (g == gap) begin
        unit_done[unit] = 1'b1;
        run             = run_next;
      end
    end
    @(negedge clk);
    unit_done = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    MFC = 1'b0;
    unit_done = 3'b000;
    bus_in = 16'hFFFF;
    #3;
    n_cmp++;
    if ({ctrl, unit_start, bus_grant, halted, fault, fault_code} !== 17'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {ctrl, unit_start, bus_grant, halted, fault, fault_code});
    end
    n_cmp++;
    if (ir !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ir: got %h expected 0000", ir);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load();
    int ce, err;
    logic found;
    do_reset();
    run = 1'b1;
    fetch_one(16'h2083, 2, ce, found);
    n_cmp++;
    if (!found || ce != 0) begin
      n_fail++;
      $display("[TB] FAIL load_fetch_timing: got found=%0d ctrl_err=%0d expected found=1 ctrl_err=0", found, ce);
    end
    n_cmp++;
    if (ir !== 16'h2083) begin
      n_fail++;
      $display("[TB] FAIL load_ir: got %h expected 2083", ir);
    end
    n_cmp++;
    if (unit_start !== 3'b001 || bus_grant !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL load_start: got start=%b grant=%b expected 001/01", unit_start, bus_grant);
    end
    wait_done(0, 3, 1'b1, err);
    n_cmp++;
    if (err != 0 || pcOut !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL load_wait_done: got err=%0d pcOut=%b expected 0/1", err, pcOut);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] prog [3];
    int ce, err, u, bad;
    logic found;
    prog[0] = 16'h3042;
    prog[1] = 16'h5001;
    prog[2] = 16'hF000;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u = model_unit(prog[i]);
      fetch_one(prog[i], $urandom_range(0, 2), ce, found);
      n_cmp++;
      if (!found || ce != 0 || ir !== prog[i]) begin
        n_fail++;
        $display("[TB] FAIL seq_fetch[%0d]: got found=%0d ctrl_err=%0d ir=%h expected 1/0/%h",
                 i, found, ce, ir, prog[i]);
      end
      if (u < 3) begin
        n_cmp++;
        if (unit_start !== 3'(1 << u) || bus_grant !== 2'(u + 1)) begin
          n_fail++;
          $display("[TB] FAIL seq_start[%0d]: got %b/%b expected %b/%b",
                   i, unit_start, bus_grant, 3'(1 << u), 2'(u + 1));
        end
        wait_done(u, $urandom_range(0, 2), 1'b1, err);
        n_cmp++;
        if (err != 0 || pcOut !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL seq_done[%0d]: got err=%0d pcOut=%b expected 0/1", i, err, pcOut);
        end
      end
    end
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (halted !== 1'b1 || fault !== 1'b0 || ctrl !== 8'h00 ||
          bus_grant !== 2'b00 || unit_start !== 3'b000) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL seq_halt_hold: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] instr;
    int ce, bad;
    logic found;
    for (int op = 12; op <= 14; op++) begin
      do_reset();
      run = 1'b1;
      instr = {4'(op), 12'($urandom)};
      fetch_one(instr, $urandom_range(0, 1), ce, found);
      n_cmp++;
      if (!found || ce != 0 || fault !== 1'b1 || fault_code !== 2'b01 || halted !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL illegal_%h: got found=%0d ce=%0d fault=%b code=%b halted=%b expected 1/0/1/01/0",
                 instr, found, ce, fault, fault_code, halted);
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        if (unit_start !== 3'b000 || ctrl !== 8'h00 || fault !== 1'b1) bad++;
        @(negedge clk);
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("[TB] FAIL illegal_hold_%h: got %0d bad cycles expected 0", instr, bad);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] instr;
    int ce, err, u;
    logic found;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 25; i++) begin
      instr = {4'($urandom_range(0, 11)), 12'($urandom)};
      u = model_unit(instr);
      fetch_one(instr, $urandom_range(0, 2), ce, found);
      n_cmp++;
      if (!found || ce != 0 || ir !== instr || unit_start !== 3'(1 << u) ||
          bus_grant !== 2'(u + 1)) begin
        n_fail++;
        $display("[TB] FAIL random_fetch_%h: got found=%0d ce=%0d ir=%h start=%b grant=%b expected start=%b grant=%b",
                 instr, found, ce, ir, unit_start, bus_grant, 3'(1 << u), 2'(u + 1));
      end
      wait_done(u, $urandom_range(0, 2), 1'b1, err);
      n_cmp++;
      if (err != 0 || pcOut !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL random_done_%h: got err=%0d pcOut=%b expected 0/1", instr, err, pcOut);
      end
    end
  endtask

  task automatic test_run_drop();
    int ce, err, bad;
    logic found;
    do_reset();
    run = 1'b1;
    fetch_one(16'h0123, 0, ce, found);
    n_cmp++;
    if (!found || ce != 0 || unit_start !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL drop_fetch: got found=%0d ce=%0d start=%b expected 1/0/010", found, ce, unit_start);
    end
    wait_done(1, 3, 1'b0, err);
    n_cmp++;
    if (err != 0 || ctrl !== 8'h00 || bus_grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL drop_idle: got err=%0d ctrl=%b grant=%b expected 0/0/00", err, ctrl, bus_grant);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (pcOut !== 1'b0 || bus_grant !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL drop_no_fetch: got %0d bad cycles expected 0", bad);
    end
    run = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pcOut !== 1'b1 || marIn !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_resume: got pcOut=%b marIn=%b expected 1/1", pcOut, marIn);
    end
  endtask

  task automatic test_reset_mid();
    int ce, err;
    logic found;
    do_reset();
    run = 1'b1;
    fetch_one(16'h4ABC, 0, ce, found);
    wait_done(2, 0, 1'b1, err);
    @(negedge clk);
    n_cmp++;
    if (memEN !== 1'b1 || ir !== 16'h4ABC) begin
      n_fail++;
      $display("[TB] FAIL rstmid_setup: got memEN=%b ir=%h expected 1/4abc", memEN, ir);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ctrl, unit_start, bus_grant, halted, fault, fault_code} !== 17'h0 || ir !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: got outs=%h ir=%h expected 0/0000",
               {ctrl, unit_start, bus_grant, halted, fault, fault_code}, ir);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pcOut !== 1'b1 || marIn !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_restart: got pcOut=%b marIn=%b expected 1/1", pcOut, marIn);
    end
  endtask

  task automatic test_watchdog();
    int ce, err, c;
    logic found;
`ifdef SEQ_WATCHDOG_EN
    do_reset();
    run = 1'b1;
    c = 0;
    while (pcOut !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    for (int k = 0; k < 5; k++) @(negedge clk);
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || ctrl !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL wd_mfc_timeout: got fault=%b code=%b ctrl=%b expected 1/10/0", fault, fault_code, ctrl);
    end
    do_reset();
    run = 1'b1;
    fetch_one(16'h2001, 3, ce, found);
    n_cmp++;
    if (!found || ce != 0 || fault !== 1'b0 || unit_start !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL wd_mfc_coincide: got found=%0d ce=%0d fault=%b start=%b expected 1/0/0/001",
               found, ce, fault, unit_start);
    end
    for (int k = 0; k < 5; k++) @(negedge clk);
    n_cmp++;
    if (fault !== 1'b1 || fault_code !== 2'b11 || bus_grant !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL wd_done_timeout: got fault=%b code=%b grant=%b expected 1/11/00", fault, fault_code, bus_grant);
    end
`else
    do_reset();
    run = 1'b1;
    fetch_one(16'h6000, 20, ce, found);
    n_cmp++;
    if (!found || ce != 0 || fault !== 1'b0 || unit_start !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL nowd_long_mfc: got found=%0d ce=%0d fault=%b start=%b expected 1/0/0/100",
               found, ce, fault, unit_start);
    end
    wait_done(2, 20, 1'b0, err);
    c = 0;
    n_cmp++;
    if (err != 0 || fault !== 1'b0 || fault_code !== 2'b00 || bus_grant !== 2'b00 || ctrl !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL nowd_long_done: got err=%0d fault=%b code=%b grant=%b expected 0/0/00/00",
               err, fault, fault_code, bus_grant);
    end
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time bound");
    $fatal(1, "[TB] time bound expired");
  end

  initial begin
    test_reset();
    test_load();
    test_sequence();
    test_illegal();
    test_random();
    test_run_drop();
    test_reset_mid();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
